// File: rtl/audio_pkg.sv
// Shared definitions for the audio DAC serializer: FSM states and default sizing.
package audio_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int SAMPLE_W_DEF      = 16;  // bits per channel
    localparam int BCLK_HALF_DIV_DEF = 16;  // iCLK cycles per AUD_BCLK half-period
    localparam int XCK_DIV           = 4;   // AUD_XCK = iCLK / XCK_DIV

endpackage

// File: rtl/audio_clk_gen.sv
// Codec clock generator: AUD_XCK (iCLK/XCK_DIV) and AUD_BCLK, plus single-cycle
// strobes marking the iCLK edge on which AUD_BCLK rises or falls.
// Both clocks sit low and their dividers are cleared whenever run is low.
module audio_clk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_HALF_DIV = BCLK_HALF_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic xck,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);

    localparam int             XCK_HALF  = XCK_DIV / 2;
    localparam int             XCK_CNT_W = (XCK_HALF > 1) ? $clog2(XCK_HALF) : 1;
    localparam logic [XCK_CNT_W-1:0] XCK_LAST = XCK_CNT_W'(XCK_HALF - 1);
    localparam logic [7:0]     DIV_LAST  = 8'(BCLK_HALF_DIV - 1);

    logic [XCK_CNT_W-1:0] xck_cnt;
    logic [7:0]           div;
    logic                 bclk_edge;

    // The strobe is valid in the cycle before the edge, so logic clocked on the
    // same iCLK edge changes together with AUD_BCLK.
    assign bclk_edge = run && (div == DIV_LAST);
    assign bclk_rise = bclk_edge && !bclk;
    assign bclk_fall = bclk_edge && bclk;

    // Master clock divider: toggle AUD_XCK every XCK_HALF iCLK cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            xck_cnt <= '0;
            xck     <= 1'b0;
        end else if (!run) begin
            xck_cnt <= '0;
            xck     <= 1'b0;
        end else if (xck_cnt == XCK_LAST) begin
            xck_cnt <= '0;
            xck     <= ~xck;
        end else begin
            xck_cnt <= xck_cnt + XCK_CNT_W'(1);
        end
    end

    // Bit clock divider: starts low, toggles when the divider hits its last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (!run) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (bclk_edge) begin
            div  <= '0;
            bclk <= ~bclk;
        end else begin
            div <= div + 8'd1;
        end
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified stereo serializer for the audio codec DAC path.
// A one-entry holding buffer takes {left, right} samples; each frame boundary
// (a BCLK falling edge where the bit counter wraps) loads the buffer, or zeros
// on underrun, into the shift register.
// Build option: define AUDIO_UNDERRUN_CNT_EN to implement the saturating
// underrun counter on o_underrun_cnt; otherwise the output is tied to zero.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int BCLK_HALF_DIV = BCLK_HALF_DIV_DEF,
    parameter int SAMPLE_W      = SAMPLE_W_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  i_cfg_done,
    input  logic                  i_valid,
    input  logic [2*SAMPLE_W-1:0] i_sample,
    output logic                  o_ready,
    output logic                  AUD_XCK,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic [15:0]           o_underrun_cnt
);

    localparam int               FRAME_BITS = 2 * SAMPLE_W;
    localparam int               BIT_W      = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] LEFT_BITS  = BIT_W'(SAMPLE_W);

    logic [1:0]            rst_sync;
    logic                  rst_n;
    state_e                state, state_next;
    logic                  run_active;
    logic                  bclk_rise, bclk_fall;
    logic                  buf_full;
    logic [FRAME_BITS-1:0] buf_data;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] load_word;
    logic [BIT_W-1:0]      bit_cnt, next_bit;
    logic                  in_frame;
    logic                  frame_start;

    // Reset synchroniser: assertion passes straight through, release takes two edges.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // FSM state register.
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // FSM next state and outputs; the datapath runs only while staying in RUN,
    // so a dropped i_cfg_done clears everything on the same edge as the exit.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and infers a latch.
        state_next = state;
        o_ready    = 1'b0;
        run_active = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_cfg_done) state_next = ST_RUN;
            end
            ST_RUN: begin
                o_ready    = !buf_full;
                run_active = i_cfg_done;
                if (!i_cfg_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    audio_clk_gen #(
        .BCLK_HALF_DIV (BCLK_HALF_DIV)
    ) u_clk_gen (
        .clk       (iCLK),
        .rst_n     (rst_n),
        .run       (run_active),
        .xck       (AUD_XCK),
        .bclk      (AUD_BCLK),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall)
    );

    // The first falling edge of a run starts a frame even though the counter is at 0.
    assign frame_start = bclk_fall && (!in_frame || bit_cnt == LAST_BIT);
    assign next_bit    = frame_start ? '0 : bit_cnt + BIT_W'(1);
    assign load_word   = buf_full ? buf_data : '0;

    // Holding buffer, bit counter and shift register; line outputs move only on BCLK falls.
    always_ff @(posedge iCLK or negedge rst_n) begin
        // NOTE: the buffer data is reset too, so a sample held at reset can
        // never be transmitted afterwards.
        if (!rst_n) begin
            buf_full    <= 1'b0;
            buf_data    <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            in_frame    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
        end else if (!run_active) begin
            buf_full    <= 1'b0;
            buf_data    <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            in_frame    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
        end else begin
            if (bclk_fall) begin
                bit_cnt     <= next_bit;
                in_frame    <= 1'b1;
                AUD_DACLRCK <= (next_bit < LEFT_BITS);
                if (frame_start) begin
                    AUD_DACDAT <= load_word[FRAME_BITS-1];
                    shreg      <= {load_word[FRAME_BITS-2:0], 1'b0};
                end else begin
                    AUD_DACDAT <= shreg[FRAME_BITS-1];
                    shreg      <= {shreg[FRAME_BITS-2:0], 1'b0};
                end
            end
            // Acceptance is listed last; it cannot meet a load of a full buffer.
            if (frame_start) buf_full <= 1'b0;
            if (i_valid && o_ready) begin
                buf_full <= 1'b1;
                buf_data <= i_sample;
            end
        end
    end

    // Data must never move on a BCLK rising edge: a frame boundary is always a fall.
    a_no_load_on_rise : assert property (@(posedge iCLK) disable iff (!rst_n)
        !(bclk_rise && frame_start));

`ifdef AUDIO_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;

    // Saturating count of frames that went out as zero fill.
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n)                                                underrun_cnt <= '0;
        else if (!run_active)                                      underrun_cnt <= '0;
        else if (frame_start && !buf_full && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end

    assign o_underrun_cnt = underrun_cnt;
`else
    assign o_underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer. A cycle-level reference model
// predicts every output from elapsed time since entering RUN and the list of
// words scheduled per frame; outputs are compared 1 ns after each iCLK edge.
module tb_audio_dac_serializer;

    localparam int HALF   = 16;
    localparam int W      = 16;
    localparam int FB     = 2 * W;
    localparam int BCLK_P = 2 * HALF;
    localparam int FRAME  = FB * BCLK_P;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_done;
    logic          valid;
    logic [FB-1:0] sample;
    logic          ready, xck, bclk, lrck, dat;
    logic [15:0]   underrun_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int            sync_cnt;     // edges since reset release (saturates at 2)
    int            run_n;        // edges since entering RUN, -1 when idle
    bit            full;
    bit            last_accept;
    logic [FB-1:0] buf_m;
    logic [FB-1:0] cur_word;
    int            und;

    audio_dac_serializer #(
        .BCLK_HALF_DIV (HALF),
        .SAMPLE_W      (W)
    ) dut (
        .iCLK           (clk),
        .iRST_N         (rst_n),
        .i_cfg_done     (cfg_done),
        .i_valid        (valid),
        .i_sample       (sample),
        .o_ready        (ready),
        .AUD_XCK        (xck),
        .AUD_BCLK       (bclk),
        .AUD_DACLRCK    (lrck),
        .AUD_DACDAT     (dat),
        .o_underrun_cnt (underrun_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t, run_n=%0d)", tag, got, exp, $time, run_n);
        end
    endtask

    function automatic void model_clear();
        run_n       = -1;
        full        = 1'b0;
        buf_m       = '0;
        cur_word    = '0;
        und         = 0;
        last_accept = 1'b0;
    endfunction

    // Advance the model by one iCLK edge using the inputs present at that edge.
    function automatic void model_edge();
        bit acc;
        last_accept = 1'b0;
        if (!rst_n) begin
            sync_cnt = 0;
            model_clear();
            return;
        end
        if (sync_cnt < 2) begin
            sync_cnt++;
            return;
        end
        if (!cfg_done) begin
            model_clear();
            return;
        end
        acc   = valid && (run_n >= 0) && !full;
        run_n = (run_n < 0) ? 0 : run_n + 1;
        if (run_n >= BCLK_P && ((run_n - BCLK_P) % FRAME) == 0) begin
            cur_word = full ? buf_m : '0;
            if (!full && und < 65535) und++;
            full = 1'b0;
        end
        if (acc) begin
            full        = 1'b1;
            buf_m       = sample;
            last_accept = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        logic [4:0] exp;
        int         p;
        exp = '0;
        if (run_n >= 0) begin
            exp[4] = !full;
            exp[3] = ((run_n / 2) % 2) == 1;
            exp[2] = ((run_n / HALF) % 2) == 1;
            if (run_n >= BCLK_P) begin
                p      = ((run_n - BCLK_P) / BCLK_P) % FB;
                exp[1] = (p < W);
                exp[0] = cur_word[FB-1-p];
            end
        end
        check("pins{rdy,xck,bclk,lrck,dat}", 32'({ready, xck, bclk, lrck, dat}), 32'(exp));
`ifdef AUDIO_UNDERRUN_CNT_EN
        check("underrun_cnt", 32'(underrun_cnt), 32'(und));
`else
        check("underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        int guard;
        rst_n    = 1'b0;
        cfg_done = 1'b0;
        valid    = 1'b0;
        sample   = '0;
        sync_cnt = 0;
        model_clear();

        // Reset, then idle with configuration pending
        repeat (5) step();
        rst_n = 1'b1;
        repeat (500) step();

        // First frame carries A5A5/0F0F; then an incrementing stream held valid
        cfg_done = 1'b1;
        step();
        valid  = 1'b1;
        sample = {16'hA5A5, 16'h0F0F};
        repeat (BCLK_P + 5 * FRAME) begin
            step();
            if (last_accept) sample = sample + 32'h0001_0001;
        end
        valid = 1'b0;

        // Starvation: zero-filled frames counted as underruns
        repeat (4 * FRAME) step();

        // Random offers at random points in each frame, some frames skipped
        for (int f = 0; f < 6; f++) begin
            int off  = int'($urandom_range(10, 900));
            bit give = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < FRAME; c++) begin
                if (give && c == off) begin
                    valid  = 1'b1;
                    sample = $urandom;
                end
                step();
                if (last_accept) valid = 1'b0;
            end
        end
        valid = 1'b0;

        // Drop configuration during bit 7 of a left word, then restart
        guard = 0;
        while (!(run_n >= BCLK_P && ((run_n - BCLK_P) % FRAME) == 7 * BCLK_P + 5) && guard < 3 * FRAME) begin
            step();
            guard++;
        end
        check("reach_bit7_bound", 32'(guard < 3 * FRAME), 32'd1);
        cfg_done = 1'b0;
        repeat (20) step();
        cfg_done = 1'b1;
        step();
        valid  = 1'b1;
        sample = $urandom;
        repeat (BCLK_P + 2 * FRAME) begin
            step();
            if (last_accept) valid = 1'b0;
        end
        valid = 1'b0;

        // Fill the buffer right after a boundary, then pulse reset mid-frame
        guard = 0;
        while (!(run_n >= BCLK_P && ((run_n - BCLK_P) % FRAME) == 0) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("reach_boundary_bound", 32'(guard < 2 * FRAME), 32'd1);
        valid  = 1'b1;
        sample = $urandom | 32'h8000_8000;
        guard  = 0;
        while (!last_accept && guard < 100) begin
            step();
            guard++;
        end
        check("accept_bound", 32'(guard < 100), 32'd1);
        valid = 1'b0;
        repeat (300) step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        #2;
        rst_n    = 1'b0;
        sync_cnt = 0;
        model_clear();
        #1;
        check_outputs();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3 + BCLK_P + 2 * FRAME) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
